axis_frame_sequencer: RTL and testbench
=======================================

Name: axis_frame_sequencer

Overview:
- Frame-level controller in front of the stream datapath (pipeline adder) inside the CNN accelerator top.
- Control plane programs frame geometry and issues start/abort.
- Block gates the upstream AXI-Stream into the datapath for exactly width x height beats, regenerates TLAST at the frame end, and reports busy, done, error, interrupt and frame count back to the control registers.

Parameters:
- DATA_WIDTH, 32, stream data width in bits; TKEEP width is DATA_WIDTH/8.
- CNT_WIDTH, 16, width of geometry fields, column/row counters and the frame counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle start pulse from the control register block.
- cfg_abort  in  1  one-cycle abort pulse.
- cfg_width  in  CNT_WIDTH  beats per row.
- cfg_height  in  CNT_WIDTH  rows per frame.
- s_axis_tdata  in  DATA_WIDTH  upstream pixel data.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  upstream ready.
- s_axis_tlast  in  1  upstream frame marker; checked only, not forwarded.
- s_axis_tkeep  in  DATA_WIDTH/8  upstream byte enables.
- m_axis_tdata  out  DATA_WIDTH  data to the datapath.
- m_axis_tvalid  out  1  valid to the datapath.
- m_axis_tready  in  1  datapath ready.
- m_axis_tlast  out  1  regenerated end-of-frame marker.
- m_axis_tkeep  out  DATA_WIDTH/8  forwarded byte enables.
- status_busy  out  1  high in RUN.
- status_done  out  1  sticky; set on frame completion, cleared by an accepted start.
- status_err  out  1  sticky error flag; cleared by an accepted start.
- status_frame_cnt  out  CNT_WIDTH  completed-frame counter; wraps at the maximum value.
- irq  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE; counters and latched geometry clear.
  - All status outputs, irq, s_axis_tready and m_axis_tvalid go to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - s_axis_tready=0 and m_axis_tvalid=0; upstream data is not consumed.
  - cfg_start with cfg_width!=0 and cfg_height!=0:
    - Latch the geometry; clear col, row, status_done and status_err.
    - Enter RUN next cycle.
  - cfg_start with either dimension 0: set status_err, stay IDLE.
- RUN:
  - Zero-latency combinational pass-through.
    - m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready.
    - tdata and tkeep forwarded unchanged.
  - Beat handshake = s_axis_tvalid & m_axis_tready.
    - On each beat: col increments.
    - At col==w-1: col returns to 0 and row increments.
  - m_axis_tlast=1 only when col==w-1 and row==h-1; combinational from the latched counters.
  - Frame length is set by the counters, never by upstream TLAST.
  - TLAST check, on each beat:
    - s_axis_tlast=1 on a non-final beat sets status_err.
    - s_axis_tlast=0 on the final beat sets status_err.
    - Frame still ends by count.
  - Final beat handshake:
    - Enter DONE; set status_done.
    - Increment status_frame_cnt, wrapping at 2^CNT_WIDTH-1 -> 0.
  - cfg_abort:
    - Return to IDLE next cycle; counters clear.
    - No done, no irq; status_err unchanged.
    - A beat handshaking in the same cycle is still passed (already accepted).
  - cfg_start is ignored in RUN.
  - cfg_start and cfg_abort in the same cycle: abort wins.
- DONE:
  - Lasts exactly 1 cycle; irq=1; both valid and ready are 0.
  - Next state is IDLE; cfg_start in DONE is ignored.
- Geometry changes on cfg_width/cfg_height during RUN have no effect until the next start.
- status_busy=1 exactly in RUN.
- Counter arithmetic is CNT_WIDTH unsigned; comparisons use latched w-1 and h-1, precomputed at start.
  - Maximum frame is (2^CNT_WIDTH-1)^2 beats.
  - No multiplier.

Optional Feature:
- Macro: AXIS_FRAME_SOF_TUSER_EN.
- Defined: adds output port m_axis_tuser, width 1.
  - Equals 1 on the first beat of a frame (col==0 and row==0) while m_axis_tvalid is high; 0 otherwise.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - The FSM state typedef (IDLE/RUN/DONE, 2-bit encoding).
  - The CNT_WIDTH default.
  - The control-register bit positions for start/abort and the status bit layout (busy bit0, done bit1, err bit2), reused by the AXI-Lite slave.
- One natural sub-module: axis_frame_counter, holding the col/row counters, wrap logic and the is_last/is_first flags.

Test Plan:
- w=4, h=2, start; 8 beats 0..7 with m_axis_tready always 1, upstream tlast on beat 7 -> 8 beats out, m_axis_tlast only on beat 7, irq 1 cycle, status_done=1, frame_cnt=1, err=0.
- w=3, h=1; m_axis_tready toggling 1,0,1,0; s_axis_tvalid gapped -> data order and count preserved, s_axis_tready mirrors m_axis_tready, tlast on the 3rd accepted beat.
- w=2, h=2; upstream tlast asserted on beat 1 -> status_err=1, frame still ends at beat 3; next valid start clears err.
- start with w=0, h=5 -> status_err=1, busy stays 0, s_axis_tready stays 0.
- w=8, h=8; abort after 10 beats -> busy drops next cycle, no irq, frame_cnt unchanged; new start runs a full 64-beat frame.
- rst_n pulled low mid-frame at beat 5 -> all outputs 0 immediately; after release a new start counts from beat 0.

Source files
------------

// File: rtl/axis_frame_sequencer_pkg.sv
// Shared types and register layout for the AXI-Stream frame sequencer.
// Also used by the AXI-Lite control slave.
package axis_frame_sequencer_pkg;

  localparam int CNT_WIDTH_DEF = 16;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/axis_frame_sequencer_if.sv
// AXI-Stream bundle used on both sides of the frame sequencer.
// master drives payload/valid, slave drives ready.
interface axis_frame_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [KEEP_WIDTH-1:0] tkeep;

  modport master (
    output tdata, tvalid, tlast, tkeep,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tkeep,
    output tready
  );
endinterface

// File: rtl/axis_frame_counter.sv
// Column/row beat counters with end-of-frame flag.
// AXIS_FRAME_SOF_TUSER_EN adds the first-beat flag.
module axis_frame_counter
  import axis_frame_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 beat,
  input  logic [CNT_WIDTH-1:0] w_last,
  input  logic [CNT_WIDTH-1:0] h_last,
`ifdef AXIS_FRAME_SOF_TUSER_EN
  output logic                 is_first,
`endif
  output logic                 is_last
);

  logic [CNT_WIDTH-1:0] col;
  logic [CNT_WIDTH-1:0] row;
  logic                 col_end;
  logic                 row_end;

  assign col_end = (col == w_last);
  assign row_end = (row == h_last);
  assign is_last = col_end & row_end;

`ifdef AXIS_FRAME_SOF_TUSER_EN
  assign is_first = (col == '0) & (row == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else begin
      unique case (1'b1)
        clr: begin
          col <= '0;
          row <= '0;
        end
        (!clr && beat && col_end): begin
          col <= '0;
          row <= row_end ? '0 : row + CNT_WIDTH'(1);
        end
        (!clr && beat && !col_end): begin
          col <= col + CNT_WIDTH'(1);
        end
        default: begin
          col <= col;
          row <= row;
        end
      endcase
    end
  end

endmodule

// File: rtl/axis_frame_sequencer.sv
// Gates an AXI-Stream into the datapath for one w x h frame, regenerates TLAST.
// AXIS_FRAME_SOF_TUSER_EN adds m_axis_tuser start-of-frame output.
module axis_frame_sequencer
  import axis_frame_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [CNT_WIDTH-1:0]  cfg_width,
  input  logic [CNT_WIDTH-1:0]  cfg_height,
  axis_frame_sequencer_if.slave  s_axis,
  axis_frame_sequencer_if.master m_axis,
`ifdef AXIS_FRAME_SOF_TUSER_EN
  output logic                  m_axis_tuser,
`endif
  output logic                  status_busy,
  output logic                  status_done,
  output logic                  status_err,
  output logic [CNT_WIDTH-1:0]  status_frame_cnt,
  output logic                  irq
);

  seq_state_t           state;
  logic [CNT_WIDTH-1:0] w_last;
  logic [CNT_WIDTH-1:0] h_last;
  logic                 run;
  logic                 beat;
  logic                 geom_ok;
  logic                 start_ok;
  logic                 cnt_clr;
  logic                 is_last;

  assign run      = (state == ST_RUN);
  assign beat     = run & s_axis.tvalid & m_axis.tready;
  assign geom_ok  = (cfg_width != '0) & (cfg_height != '0);
  assign start_ok = (state == ST_IDLE) & cfg_start & geom_ok;
  assign cnt_clr  = start_ok | (run & cfg_abort);

  // Zero-latency pass-through, gated shut outside RUN
  assign m_axis.tdata  = s_axis.tdata[DATA_WIDTH-1:0];
  assign m_axis.tkeep  = s_axis.tkeep[DATA_WIDTH/8-1:0];
  assign m_axis.tvalid = run & s_axis.tvalid;
  assign m_axis.tlast  = run & is_last;
  assign s_axis.tready = run & m_axis.tready;

`ifdef AXIS_FRAME_SOF_TUSER_EN
  logic is_first;

  assign m_axis_tuser = run & s_axis.tvalid & is_first;
`endif

  axis_frame_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .beat     (beat),
    .w_last   (w_last),
    .h_last   (h_last),
`ifdef AXIS_FRAME_SOF_TUSER_EN
    .is_first (is_first),
`endif
    .is_last  (is_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      w_last           <= '0;
      h_last           <= '0;
      status_busy      <= 1'b0;
      status_done      <= 1'b0;
      status_err       <= 1'b0;
      status_frame_cnt <= '0;
      irq              <= 1'b0;
    end else begin
      irq <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            if (geom_ok) begin
              w_last      <= cfg_width - CNT_WIDTH'(1);
              h_last      <= cfg_height - CNT_WIDTH'(1);
              status_done <= 1'b0;
              status_err  <= 1'b0;
              status_busy <= 1'b1;
              state       <= ST_RUN;
            end else begin
              status_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Abort wins over a coincident final beat and leaves err alone
          if (cfg_abort) begin
            status_busy <= 1'b0;
            state       <= ST_IDLE;
          end else if (beat) begin
            if (s_axis.tlast != is_last) status_err <= 1'b1;
            if (is_last) begin
              status_busy      <= 1'b0;
              status_done      <= 1'b1;
              irq              <= 1'b1;
              status_frame_cnt <= status_frame_cnt + CNT_WIDTH'(1);
              state            <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_sequencer.sv
// Directed self-checking bench for axis_frame_sequencer.
// Build with AXIS_FRAME_SOF_TUSER_EN to also check m_axis_tuser.
module tb_axis_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic        cfg_abort;
  logic [15:0] cfg_width;
  logic [15:0] cfg_height;
  logic        status_busy;
  logic        status_done;
  logic        status_err;
  logic [15:0] status_frame_cnt;
  logic        irq;
`ifdef AXIS_FRAME_SOF_TUSER_EN
  logic        m_axis_tuser;
`endif

  axis_frame_sequencer_if #(.DATA_WIDTH(32)) s_if ();
  axis_frame_sequencer_if #(.DATA_WIDTH(32)) m_if ();

  axis_frame_sequencer #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_start        (cfg_start),
    .cfg_abort        (cfg_abort),
    .cfg_width        (cfg_width),
    .cfg_height       (cfg_height),
    .s_axis           (s_if),
    .m_axis           (m_if),
`ifdef AXIS_FRAME_SOF_TUSER_EN
    .m_axis_tuser     (m_axis_tuser),
`endif
    .status_busy      (status_busy),
    .status_done      (status_done),
    .status_err       (status_err),
    .status_frame_cnt (status_frame_cnt),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int irq_seen = 0;
  int k;
  int irq_mark;
  int last_seen;

  logic [31:0] got_data;
  logic [3:0]  got_keep;
  logic        got_last;
  logic        got_user;

  always @(negedge clk) if (irq) irq_seen++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic start_frame(input logic [15:0] w, input logic [15:0] h);
    cfg_width  = w;
    cfg_height = h;
    cfg_start  = 1'b1;
    @(posedge clk); #1;
    cfg_start  = 1'b0;
  endtask

  // Present one beat, wait (bounded) for the handshake, capture outputs
  task automatic send_beat(input logic [31:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tlast  = last;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_if.tready) begin
        got_data = m_if.tdata;
        got_keep = m_if.tkeep;
        got_last = m_if.tlast;
`ifdef AXIS_FRAME_SOF_TUSER_EN
        got_user = m_axis_tuser;
`else
        got_user = 1'b0;
`endif
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end else begin
      chk("beat_timeout", 32'(ok), 32'd1);
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    cfg_start   = 1'b0;
    cfg_abort   = 1'b0;
    cfg_width   = '0;
    cfg_height  = '0;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b1;
    s_if.tlast  = 1'b0;
    s_if.tkeep  = 4'hA;
    m_if.tready = 1'b1;
    got_user    = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(status_busy), 32'd0);
    chk("rst_done", 32'(status_done), 32'd0);
    chk("rst_err", 32'(status_err), 32'd0);
    chk("rst_cnt", 32'(status_frame_cnt), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_s_ready", 32'(s_if.tready), 32'd0);
    chk("rst_m_valid", 32'(m_if.tvalid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_if.tvalid = 1'b0;
    @(posedge clk); #1;

    // Idle must not consume data
    s_if.tvalid = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", 32'(s_if.tready), 32'd0);
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;

    // w=4 h=2, full rate
    start_frame(16'd4, 16'd2);
    @(negedge clk);
    chk("t1_busy", 32'(status_busy), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      send_beat(32'(i), i == 7);
      chk("t1_data", got_data, 32'(i));
      chk("t1_last", 32'(got_last), 32'(i == 7));
`ifdef AXIS_FRAME_SOF_TUSER_EN
      chk("t1_tuser", 32'(got_user), 32'(i == 0));
`endif
    end
    chk("t1_keep", 32'(got_keep), 32'hA);
    @(negedge clk);
    chk("t1_irq", 32'(irq), 32'd1);
    chk("t1_busy_off", 32'(status_busy), 32'd0);
    chk("t1_done", 32'(status_done), 32'd1);
    chk("t1_cnt", 32'(status_frame_cnt), 32'd1);
    chk("t1_err", 32'(status_err), 32'd0);
    chk("t1_done_ready", 32'(s_if.tready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_irq_pulse", 32'(irq), 32'd0);
    chk("t1_irq_seen", 32'(irq_seen), 32'd1);
    @(posedge clk); #1;

    // w=3 h=1, toggling ready and gapped valid
    start_frame(16'd3, 16'd1);
    k = 0;
    for (int c = 0; c < 40 && k < 3; c++) begin
      m_if.tready = (c % 2 == 0);
      s_if.tvalid = (c % 3 != 1);
      s_if.tdata  = 32'h100 + 32'(k);
      s_if.tlast  = (k == 2);
      @(negedge clk);
      if (c < 4) chk("t2_ready_mirror", 32'(s_if.tready), 32'(m_if.tready));
      if (s_if.tvalid && m_if.tready) begin
        chk("t2_data", m_if.tdata, 32'h100 + 32'(k));
        chk("t2_last", 32'(m_if.tlast), 32'(k == 2));
        k++;
      end
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    chk("t2_beats", 32'(k), 32'd3);
    @(negedge clk);
    chk("t2_irq", 32'(irq), 32'd1);
    chk("t2_cnt", 32'(status_frame_cnt), 32'd2);
    chk("t2_err", 32'(status_err), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // w=2 h=2, early upstream tlast
    start_frame(16'd2, 16'd2);
    @(negedge clk);
    chk("t3_done_clr", 32'(status_done), 32'd0);
    @(posedge clk); #1;
    send_beat(32'h20, 1'b0);
    send_beat(32'h21, 1'b1);
    @(negedge clk);
    chk("t3_err_set", 32'(status_err), 32'd1);
    chk("t3_still_busy", 32'(status_busy), 32'd1);
    @(posedge clk); #1;
    send_beat(32'h22, 1'b0);
    chk("t3_last2", 32'(got_last), 32'd0);
    send_beat(32'h23, 1'b1);
    chk("t3_last3", 32'(got_last), 32'd1);
    @(negedge clk);
    chk("t3_done", 32'(status_done), 32'd1);
    chk("t3_err_keep", 32'(status_err), 32'd1);
    chk("t3_cnt", 32'(status_frame_cnt), 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;

    start_frame(16'd1, 16'd1);
    @(negedge clk);
    chk("t3_err_clr", 32'(status_err), 32'd0);
    @(posedge clk); #1;
    send_beat(32'h30, 1'b1);
    chk("t3_1x1_last", 32'(got_last), 32'd1);
    @(negedge clk);
    chk("t3_1x1_cnt", 32'(status_frame_cnt), 32'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Zero width start
    s_if.tvalid = 1'b1;
    start_frame(16'd0, 16'd5);
    @(negedge clk);
    chk("t4_err", 32'(status_err), 32'd1);
    chk("t4_busy", 32'(status_busy), 32'd0);
    chk("t4_s_ready", 32'(s_if.tready), 32'd0);
    chk("t4_m_valid", 32'(m_if.tvalid), 32'd0);
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;

    // w=8 h=8, abort (with coincident start) after 10 beats
    start_frame(16'd8, 16'd8);
    for (int i = 0; i < 10; i++) send_beat(32'(i), 1'b0);
    irq_mark  = irq_seen;
    cfg_abort = 1'b1;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    cfg_start = 1'b0;
    s_if.tvalid = 1'b1;
    @(negedge clk);
    chk("t5_busy_off", 32'(status_busy), 32'd0);
    chk("t5_s_ready", 32'(s_if.tready), 32'd0);
    chk("t5_cnt", 32'(status_frame_cnt), 32'd4);
    chk("t5_done", 32'(status_done), 32'd0);
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    @(posedge clk); #1;
    chk("t5_no_irq", 32'(irq_seen), 32'(irq_mark));

    start_frame(16'd8, 16'd8);
    last_seen = 0;
    for (int i = 0; i < 64; i++) begin
      send_beat(32'h400 + 32'(i), i == 63);
      if (got_last) last_seen++;
      if (i == 0 || i == 63) chk("t5_data", got_data, 32'h400 + 32'(i));
    end
    chk("t5_final_last", 32'(got_last), 32'd1);
    chk("t5_last_count", 32'(last_seen), 32'd1);
    @(negedge clk);
    chk("t5_irq", 32'(irq), 32'd1);
    chk("t5_cnt2", 32'(status_frame_cnt), 32'd5);
    chk("t5_err", 32'(status_err), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset mid-frame at beat 5
    start_frame(16'd4, 16'd4);
    for (int i = 0; i < 5; i++) send_beat(32'(i), 1'b0);
    s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(status_busy), 32'd0);
    chk("t6_s_ready", 32'(s_if.tready), 32'd0);
    chk("t6_m_valid", 32'(m_if.tvalid), 32'd0);
    chk("t6_m_last", 32'(m_if.tlast), 32'd0);
    chk("t6_cnt", 32'(status_frame_cnt), 32'd0);
    chk("t6_done", 32'(status_done), 32'd0);
    chk("t6_irq", 32'(irq), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_if.tvalid = 1'b0;
    @(posedge clk); #1;
    start_frame(16'd2, 16'd1);
    send_beat(32'h60, 1'b0);
    chk("t6_b0_last", 32'(got_last), 32'd0);
    send_beat(32'h61, 1'b1);
    chk("t6_b1_last", 32'(got_last), 32'd1);
    @(negedge clk);
    chk("t6_cnt2", 32'(status_frame_cnt), 32'd1);
    chk("t6_err", 32'(status_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
